// File: rtl/t_test_pkg.sv
// Shared definitions for the t_test stream (producer and consumer sides).
package t_test_pkg;

  // FSM states of the producer.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } t_prod_state_e;

  // Default data word width shared by producer and consumer.
  localparam int T_TEST_DATA_W = 8;

  // Data word carried on the stream at the default width.
  typedef logic [T_TEST_DATA_W-1:0] t_test_data_t;

  // Even parity of a default-width data word.
  function automatic logic t_test_parity(input t_test_data_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/producer_tick_gen.sv
// Clock-enable divider: emits a one-cycle registered tick every RATIO clk
// cycles while enabled; the count is held at zero while disabled.
module producer_tick_gen #(
  parameter int RATIO = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int DIV_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RATIO - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // Next divider count and tick; wrap at RATIO-1, clear when disabled.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (i_en) begin
      tick_d = (div_q == DIV_MAX);
      if (div_q == DIV_MAX) begin
        div_d = {DIV_W{1'b0}};
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = {DIV_W{1'b0}};
    end
  end

  // Divider and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= {DIV_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/t_test_producer.sv
// Transmit end of the t_test stream: bursts of incrementing words on a
// valid/ready handshake, started by a tick and gated by a toggle switch.
// Optional feature: define T_TEST_PRODUCER_PARITY_EN to add o_parity.
module t_test_producer
  import t_test_pkg::*;
#(
  parameter int DATA_W    = T_TEST_DATA_W,
  parameter int RATIO     = 10,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_en,
  output logic              o_overrun
`ifdef T_TEST_PRODUCER_PARITY_EN
  ,
  output logic              o_parity
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic              sw_q, sw_d;
  logic              en_q, en_d;
  logic              tick_s;
  logic              hs_s;
  logic [DATA_W-1:0] cnt_inc_s;
  logic [BEAT_W-1:0] beat_inc_s;

  t_prod_state_e     state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [DATA_W-1:0] cnt_q;
  logic              valid_q;
  logic              last_q;
  logic              overrun_q;

  producer_tick_gen #(
    .RATIO (RATIO)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en_q),
    .o_tick (tick_s)
  );

  // Switch edge detect: each rising edge of sw flips the enable.
  always_comb begin
    sw_d = sw;
    if (sw && !sw_q) begin
      en_d = !en_q;
    end else begin
      en_d = en_q;
    end
  end

  // Switch history and enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      sw_q <= sw_d;
      en_q <= en_d;
    end
  end

  // Handshake and incremented counters feeding the FSM.
  always_comb begin
    hs_s       = valid_q && i_ready;
    cnt_inc_s  = cnt_q + DATA_W'(1);
    beat_inc_s = beat_q + BEAT_W'(1);
  end

  // Burst FSM; a tick seen while a burst is in flight is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= {BEAT_W{1'b0}};
      cnt_q     <= {DATA_W{1'b0}};
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (tick_s && (state_q == SEND)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick_s) begin
            state_q <= SEND;
            beat_q  <= {BEAT_W{1'b0}};
            valid_q <= 1'b1;
            last_q  <= (BEAT_LAST == {BEAT_W{1'b0}});
          end
        end
        SEND: begin
          if (hs_s) begin
            cnt_q <= cnt_inc_s;
            if (beat_q == BEAT_LAST) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              beat_q <= beat_inc_s;
              last_q <= (beat_inc_s == BEAT_LAST);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef T_TEST_PRODUCER_PARITY_EN
  logic parity_q;

  // Parity tracks the data register: it changes only when the word advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (hs_s && (state_q == SEND)) begin
      parity_q <= ^cnt_inc_s;
    end else begin
      parity_q <= parity_q;
    end
  end

  assign o_parity = parity_q;
`endif

  assign o_valid   = valid_q;
  assign o_data    = cnt_q;
  assign o_last    = last_q;
  assign o_en      = en_q;
  assign o_overrun = overrun_q;

endmodule

// File: doc/t_test_producer.md
# t_test_producer

- Transmit end of the `t_test` stream; the `consumer` modport sinks what this block produces.
- Generates bursts of incrementing data words on a valid/ready handshake, paced by an internal clock-enable tick.
- Bursts start and stop on a toggle switch input.
- Sits beside the consumer in the top level as the stimulus source for it.

## Interface
Parameters:
- `DATA_W`, 8, data word width; counter wraps at 2^DATA_W.
- `RATIO`, 10, tick period in clk cycles (≥2).
- `BURST_LEN`, 4, words per burst (≥1).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  1  toggle request, synchronous to clk; each rising edge flips the enable.
- `i_ready`  in  1  consumer ready.
- `o_valid`  out  1  word available.
- `o_data`  out  DATA_W  word value.
- `o_last`  out  1  final word of the burst, qualified by `o_valid`.
- `o_en`  out  1  current enable state.
- `o_overrun`  out  1  sticky; a tick was lost while a burst was in flight.

## Operation
- **Switch edge detect**
  - `sw_q` registers `sw`.
  - `sw && !sw_q` flips `en` at that edge.
- **Tick divider**
  - Counts 0..RATIO-1 while `en`=1.
  - Held at 0 while `en`=0.
  - `tick` = (div == RATIO-1) && `en`.
- **FSM states:** IDLE, SEND.
  - IDLE: `tick` -> SEND. Load `beat`=0. Assert `o_valid`.
  - SEND: on `o_valid && i_ready`, increment `cnt` and `beat`.
  - SEND: if `beat` == BURST_LEN-1, go to IDLE and drop `o_valid`.
- **Data rules**
  - `o_data` = `cnt`, and `cnt` persists across bursts.
  - `cnt` wraps modulo 2^DATA_W with no saturation.
  - `o_last` = SEND && `beat` == BURST_LEN-1.
- **Handshake rules**
  - Once `o_valid` is high, `o_data`/`o_last` are stable until accepted.
  - `o_valid` never drops without a handshake, except on reset.
- **Boundary conditions**
  - Tick in SEND: burst is not queued; `o_overrun` sets and stays set until reset.
  - `en` cleared mid-burst: the current burst completes through `o_last`; no further bursts start. The divider resets.
  - `sw` edge and `tick` in the same cycle: the tick is honored (uses the pre-toggle `en`).
  - BURST_LEN=1: every word carries `o_last`.
- **Reset (asynchronous, any time, including mid-burst)**
  - All outputs go to 0, with `o_data`=0.
  - `en`=0, `cnt`=0, FSM=IDLE, divider=0.
  - An in-flight word is discarded.

## Timing
- `sw` high sampled at edge N -> `o_en`=1 after edge N.
- First `tick` is RATIO cycles after `en` rises.
- `o_valid` asserts the cycle after `tick`.
- With `i_ready` held high, one word per cycle: a burst takes BURST_LEN cycles.
- Ticks then recur every RATIO cycles.
- All outputs are registered; there is no combinational path from `i_ready` to any output.
- When RATIO ≤ BURST_LEN, every burst overruns. This is legal; only the flag reports it.

## Configuration
- Macro `T_TEST_PRODUCER_PARITY_EN`.
  - Defined: adds output `o_parity`, 1 bit, the even parity (XOR reduction) of `o_data`. It is registered with the data, held with it under backpressure, and resets to 0.
  - Undefined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Package `t_test_pkg` holds:
  - the FSM state enum `t_prod_state_e` (IDLE, SEND);
  - default `DATA_W` constant shared with the consumer;
  - data word typedef `t_test_data_t`.
- Sub-module `producer_tick_gen` (params RATIO; ports `clk`, `rst_n`, `i_en`, `o_tick`) is the divider. Divider and FSM stay separable, so the tick is testable alone.

## Test plan
All scenarios use DATA_W=8, RATIO=10, BURST_LEN=4.
1. Assert `rst_n`=0 mid-run with `o_valid`=1 -> all outputs 0 within the same cycle; after release, no `o_valid` until `sw` is pulsed.
2. One-cycle `sw` pulse, `i_ready`=1 -> `o_en`=1 next cycle; `o_valid` first high 11 cycles after `en` rises; data 0,1,2,3 on consecutive cycles, `o_last` only with 3; next burst 4..7 ten cycles after the previous tick.
3. `i_ready`=0 for 5 cycles while word 2 is presented -> `o_valid`=1 and `o_data`=2 held stable for all 5 cycles; 3 follows one cycle after `i_ready` returns.
4. Run 64 bursts with `i_ready`=1 -> word 255 is the last of burst 64; burst 65 starts at 0.
5. `i_ready`=0 for 20 cycles during a burst -> tick falls in SEND, `o_overrun`=1 and stays set after the burst; total words = 4 per accepted burst only.
6. `sw` pulse while word 1 is presented -> words 1..3 still delivered with `o_last` on 3; `o_en`=0; no `o_valid` for the next 50 cycles.
   - With `T_TEST_PRODUCER_PARITY_EN`: `o_parity` checked on every word (e.g. data 3 -> 0, data 7 -> 1).
